// File: rtl/attn_pe_scheduler.sv
// attn_pe_scheduler
//   Sequences one Attention_PE across a job of N (query-row, key-row) pairs.
//   For each pair the Q and K chunk streams are joined and CHUNKS beats are
//   issued to the PE. The PE's per-time-step partial sums are accumulated
//   over all chunks, and one TIME_STEPS-wide score vector is presented on a
//   valid/ready port.
//
// Optional feature:
//   ATTN_SCHED_SAT_EN  defined   -> accumulator lanes saturate at 2^ACC_W-1
//                      undefined -> accumulator lanes wrap modulo 2^ACC_W
//
// Ports:
//   s_clk, s_rst           clock, asynchronous active-high reset
//   i_start, i_pair_num    job start pulse and pair count (sampled in IDLE)
//   o_busy, o_done, o_err  status: not idle, end-of-job pulse, sticky error
//   i_q_*/o_q_ready        query chunk stream
//   i_k_*/o_k_ready        key chunk stream
//   o_pe_valid/query/key   beat issued to the PE
//   i_pe_valid/data        PE per-time-step partial sums
//   o_score_*/i_score_ready score vector output handshake
module attn_pe_scheduler #(
  parameter int SYSTOLIC_UNIT_NUM = 8,
  parameter int TIME_STEPS        = 4,
  parameter int CHUNKS            = 24,
  parameter int PW                = $clog2(2*SYSTOLIC_UNIT_NUM),
  parameter int ACC_W             = 10
) (
  input  logic                                    s_clk,
  input  logic                                    s_rst,
  input  logic                                    i_start,
  input  logic [15:0]                             i_pair_num,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_err,
  input  logic                                    i_q_valid,
  input  logic [2*SYSTOLIC_UNIT_NUM*TIME_STEPS-1:0] i_q_data,
  output logic                                    o_q_ready,
  input  logic                                    i_k_valid,
  input  logic [2*SYSTOLIC_UNIT_NUM*TIME_STEPS-1:0] i_k_data,
  output logic                                    o_k_ready,
  output logic                                    o_pe_valid,
  output logic [2*SYSTOLIC_UNIT_NUM*TIME_STEPS-1:0] o_pe_query,
  output logic [2*SYSTOLIC_UNIT_NUM*TIME_STEPS-1:0] o_pe_key,
  input  logic                                    i_pe_valid,
  input  logic [PW*TIME_STEPS-1:0]                i_pe_data,
  output logic                                    o_score_valid,
  output logic [ACC_W*TIME_STEPS-1:0]             o_score_data,
  output logic                                    o_score_last,
  input  logic                                    i_score_ready
);

  localparam int CW = $clog2(CHUNKS + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} stateT;
  stateT state, stateNext;

  logic [15:0]                        pairCount;
  logic [15:0]                        pairIdx;
  logic [CW-1:0]                      issueCnt;
  logic [CW-1:0]                      resCnt;
  logic [TIME_STEPS-1:0][ACC_W-1:0]   accVec;
  logic [TIME_STEPS-1:0][ACC_W-1:0]   accSum;

  logic inIssue, inActive, fire, lastFire, peAccept, peUnexpected;
  logic lastResult, scoreHs, startJob, startEmpty, isLastPair;

  // One accumulator lane plus one zero-extended PE lane, with the overflow
  // behaviour selected at build time.
  function automatic logic [ACC_W-1:0] addLane(input logic [ACC_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - PW){1'b0}}, b};
`ifdef ATTN_SCHED_SAT_EN
    addLane = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    addLane = s[ACC_W-1:0];
`endif
  endfunction

  assign inIssue      = (state == ISSUE);
  assign inActive     = (state == ISSUE) || (state == DRAIN);
  assign fire         = inIssue && i_q_valid && i_k_valid;
  assign lastFire     = fire && (issueCnt == LAST_CHUNK);
  assign peAccept     = inActive && i_pe_valid;
  assign peUnexpected = ((state == IDLE) || (state == OUT)) && i_pe_valid;
  assign lastResult   = peAccept && (resCnt == LAST_CHUNK);
  assign scoreHs      = (state == OUT) && o_score_valid && i_score_ready;
  assign startJob     = (state == IDLE) && i_start && (i_pair_num != 16'd0);
  assign startEmpty   = (state == IDLE) && i_start && (i_pair_num == 16'd0);
  assign isLastPair   = (pairIdx == pairCount - 16'd1);

  // Running sum including the PE beat arriving this cycle; it is both the
  // next accumulator value and, on the final beat, the score itself.
  always_comb begin
    accSum = accVec;
    for (int t = 0; t < TIME_STEPS; t++) begin
      accSum[t] = addLane(accVec[t], i_pe_data[PW*t +: PW]);
    end
  end

  // State register.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic. The final result check comes first so a PE latency
  // shorter than expected can never strand the FSM in ISSUE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (startJob) stateNext = ISSUE;
      ISSUE: begin
        if (lastResult)    stateNext = OUT;
        else if (lastFire) stateNext = DRAIN;
      end
      DRAIN: if (lastResult) stateNext = OUT;
      OUT:   if (scoreHs) stateNext = o_score_last ? IDLE : ISSUE;
      default: stateNext = IDLE;
    endcase
  end

  // Combinational outputs. Each stream is only told ready when the other
  // stream has data, so a chunk is never taken from one side alone.
  always_comb begin
    o_busy    = (state != IDLE);
    o_q_ready = inIssue && i_k_valid;
    o_k_ready = inIssue && i_q_valid;
  end

  // Datapath: PE issue register, counters, accumulators, score register and
  // status flags. The error set is written after the start clear so a stray
  // result in the start cycle is still reported.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      pairCount     <= '0;
      pairIdx       <= '0;
      issueCnt      <= '0;
      resCnt        <= '0;
      accVec        <= '0;
      o_pe_valid    <= 1'b0;
      o_pe_query    <= '0;
      o_pe_key      <= '0;
      o_score_valid <= 1'b0;
      o_score_data  <= '0;
      o_score_last  <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_pe_valid <= fire;
      o_done     <= startEmpty || (scoreHs && o_score_last);
      if (fire) begin
        o_pe_query <= i_q_data;
        o_pe_key   <= i_k_data;
        issueCnt   <= issueCnt + 1'b1;
      end
      if (startJob) begin
        pairCount <= i_pair_num;
        pairIdx   <= '0;
        issueCnt  <= '0;
        resCnt    <= '0;
        accVec    <= '0;
        o_err     <= 1'b0;
      end
      if (peAccept) begin
        accVec <= accSum;
        resCnt <= resCnt + 1'b1;
      end
      if (lastResult) begin
        o_score_data  <= accSum;
        o_score_valid <= 1'b1;
        o_score_last  <= isLastPair;
      end
      if (scoreHs) begin
        o_score_valid <= 1'b0;
        o_score_last  <= 1'b0;
        if (!o_score_last) begin
          accVec   <= '0;
          issueCnt <= '0;
          resCnt   <= '0;
          pairIdx  <= pairIdx + 16'd1;
        end
      end
      if (peUnexpected) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_attn_pe_scheduler.sv
// tb_attn_pe_scheduler
//   Drives attn_pe_scheduler with queued Q/K chunks under several valid and
//   ready patterns, models the PE as a 3-cycle pipeline, and scores every
//   output vector against sums computed directly from the queued chunks.
//   A second instance with ACC_W=8 exercises lane overflow (wrap or
//   saturate, depending on ATTN_SCHED_SAT_EN).
module tb_attn_pe_scheduler;

  localparam int SUN   = 8;
  localparam int TS    = 4;
  localparam int CH    = 24;
  localparam int PW    = 4;
  localparam int ACC_W = 10;
  localparam int LW    = 2*SUN;
  localparam int DW    = LW*TS;

  typedef struct {
    logic [ACC_W*TS-1:0] data;
    logic                last;
  } expT;

  logic s_clk = 1'b0;
  logic s_rst;
  always #5 s_clk = ~s_clk;

  logic              i_start, o_busy, o_done, o_err;
  logic [15:0]       i_pair_num;
  logic              i_q_valid, o_q_ready, i_k_valid, o_k_ready;
  logic [DW-1:0]     i_q_data, i_k_data, o_pe_query, o_pe_key;
  logic              o_pe_valid, i_pe_valid;
  logic [PW*TS-1:0]  i_pe_data;
  logic              o_score_valid, o_score_last, i_score_ready;
  logic [ACC_W*TS-1:0] o_score_data;

  attn_pe_scheduler #(.SYSTOLIC_UNIT_NUM(SUN), .TIME_STEPS(TS), .CHUNKS(CH),
                      .ACC_W(ACC_W)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .i_pair_num(i_pair_num),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .i_q_valid(i_q_valid), .i_q_data(i_q_data), .o_q_ready(o_q_ready),
    .i_k_valid(i_k_valid), .i_k_data(i_k_data), .o_k_ready(o_k_ready),
    .o_pe_valid(o_pe_valid), .o_pe_query(o_pe_query), .o_pe_key(o_pe_key),
    .i_pe_valid(i_pe_valid), .i_pe_data(i_pe_data),
    .o_score_valid(o_score_valid), .o_score_data(o_score_data),
    .o_score_last(o_score_last), .i_score_ready(i_score_ready));

  // Second instance with narrow lanes for the overflow check.
  logic              s8Start, s8Go, s8Busy, s8Done, s8Err;
  logic              s8QReady, s8KReady, s8PeValidOut, s8PeValidIn;
  logic [DW-1:0]     s8Ones, s8PeQuery, s8PeKey;
  logic [PW*TS-1:0]  s8PeData;
  logic              s8ScoreValid, s8ScoreLast;
  logic [8*TS-1:0]   s8ScoreData;

  attn_pe_scheduler #(.SYSTOLIC_UNIT_NUM(SUN), .TIME_STEPS(TS), .CHUNKS(CH),
                      .ACC_W(8)) dut8 (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(s8Start), .i_pair_num(16'd1),
    .o_busy(s8Busy), .o_done(s8Done), .o_err(s8Err),
    .i_q_valid(s8Go), .i_q_data(s8Ones), .o_q_ready(s8QReady),
    .i_k_valid(s8Go), .i_k_data(s8Ones), .o_k_ready(s8KReady),
    .o_pe_valid(s8PeValidOut), .o_pe_query(s8PeQuery), .o_pe_key(s8PeKey),
    .i_pe_valid(s8PeValidIn), .i_pe_data(s8PeData),
    .o_score_valid(s8ScoreValid), .o_score_data(s8ScoreData),
    .o_score_last(s8ScoreLast), .i_score_ready(1'b1));

  int nCompared = 0;
  int nFailed   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
    end
  endtask

  // The bench's PE: each time-step lane is the popcount of Q AND K over the
  // lower 15 spikes of that lane, so it always fits in PW bits.
  function automatic logic [PW*TS-1:0] peFunc(input logic [DW-1:0] q,
                                              input logic [DW-1:0] k);
    logic [PW*TS-1:0] r;
    logic [LW-1:0]    m;
    r = '0;
    for (int t = 0; t < TS; t++) begin
      m = q[LW*t +: LW] & k[LW*t +: LW];
      m[LW-1] = 1'b0;
      r[PW*t +: PW] = PW'($countones(m));
    end
    return r;
  endfunction

  function automatic int laneModel(input int sum, input int w);
    int maxV;
    maxV = (1 << w) - 1;
`ifdef ATTN_SCHED_SAT_EN
    return (sum > maxV) ? maxV : sum;
`else
    return sum % (maxV + 1);
`endif
  endfunction

  // PE model with 3-cycle latency from o_pe_valid to i_pe_valid.
  logic [2:0]       peV = '0;
  logic [PW*TS-1:0] peD [3];
  logic             spurious = 1'b0;
  always @(posedge s_clk) begin
    peV    <= {peV[1:0], o_pe_valid};
    peD[0] <= peFunc(o_pe_query, o_pe_key);
    peD[1] <= peD[0];
    peD[2] <= peD[1];
  end
  assign i_pe_valid = peV[2] | spurious;
  assign i_pe_data  = spurious ? '1 : peD[2];

  // Narrow instance's PE: 1-cycle latency, constant all-ones data.
  always @(posedge s_clk) s8PeValidIn <= s8PeValidOut;
  assign s8PeData = peFunc(s8Ones, s8Ones);

  // Stimulus queues and driver controls.
  logic [DW-1:0] qStim[$];
  logic [DW-1:0] kStim[$];
  expT           expQ[$];
  int            qMode = 0, kMode = 0;
  bit            readyRandom = 1'b0;
  logic          readyLevel  = 1'b1;
  int            qUsed = 0, kUsed = 0, donePulses = 0, cyc = 0;
  int            scoreRise[$];

  function automatic logic validFor(input int mode, input bit phase);
    if (mode == 0)      return 1'b1;
    else if (mode == 1) return phase;
    else                return 1'($urandom_range(0, 1));
  endfunction

  // Stream driver: pops a chunk after its handshake and presents the next.
  initial begin
    bit qTake, kTake, phase;
    phase = 1'b1;
    i_q_valid = 1'b0; i_k_valid = 1'b0; i_q_data = '0; i_k_data = '0;
    i_score_ready = 1'b1;
    forever begin
      @(negedge s_clk);
      qTake = i_q_valid && o_q_ready;
      kTake = i_k_valid && o_k_ready;
      @(posedge s_clk);
      #1;
      if (qTake && qStim.size() > 0) void'(qStim.pop_front());
      if (kTake && kStim.size() > 0) void'(kStim.pop_front());
      phase = !phase;
      i_q_valid = (qStim.size() > 0) && validFor(qMode, phase);
      i_k_valid = (kStim.size() > 0) && validFor(kMode, phase);
      i_q_data  = (qStim.size() > 0) ? qStim[0] : '0;
      i_k_data  = (kStim.size() > 0) ? kStim[0] : '0;
      i_score_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  // Monitor: joint consumption, done timing, hold-while-stalled and the
  // score scoreboard.
  initial begin
    bit                  holdPrev, doneExp, prevValid;
    logic [ACC_W*TS-1:0] heldData;
    logic                heldLast;
    expT                 e;
    holdPrev = 0; doneExp = 0; prevValid = 0; heldData = '0; heldLast = 0;
    forever begin
      @(negedge s_clk);
      cyc++;
      if (s_rst) begin
        holdPrev = 0; doneExp = 0; prevValid = 0;
      end else begin
        if ((o_q_ready && i_q_valid) || (o_k_ready && i_k_valid)) begin
          checkOutput("jointFire", o_q_ready && i_q_valid, o_k_ready && i_k_valid);
          if (o_q_ready && i_q_valid) qUsed++;
          if (o_k_ready && i_k_valid) kUsed++;
        end
        if (o_done || doneExp) checkOutput("donePulse", o_done, doneExp);
        if (o_done) donePulses++;
        doneExp = (i_start && !o_busy && i_pair_num == 16'd0) ||
                  (o_score_valid && i_score_ready && o_score_last);
        if (holdPrev) begin
          checkOutput("holdValid", o_score_valid, 1);
          checkOutput("holdData", o_score_data, heldData);
          checkOutput("holdLast", o_score_last, heldLast);
        end
        if (o_score_valid && !i_score_ready) begin
          checkOutput("stallNoIssue", {o_q_ready, o_k_ready, o_pe_valid}, 0);
          holdPrev = 1; heldData = o_score_data; heldLast = o_score_last;
        end else begin
          holdPrev = 0;
        end
        if (o_score_valid && i_score_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedScore", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("scoreData", o_score_data, e.data);
            checkOutput("scoreLast", o_score_last, e.last);
          end
        end
        if (o_score_valid && !prevValid) scoreRise.push_back(cyc);
        prevValid = o_score_valid;
      end
    end
  end

  // Queue the chunks of nPairs pairs and push each pair's expected score.
  task automatic applyStimulus(input int nPairs, input bit allOnes,
                               input int qm, input int km);
    logic [DW-1:0]    q, k;
    logic [PW*TS-1:0] pd;
    int               sums[TS];
    expT              e;
    qMode = qm;
    kMode = km;
    for (int p = 0; p < nPairs; p++) begin
      for (int t = 0; t < TS; t++) sums[t] = 0;
      for (int c = 0; c < CH; c++) begin
        q = allOnes ? '1 : DW'({$urandom, $urandom});
        k = allOnes ? '1 : DW'({$urandom, $urandom});
        qStim.push_back(q);
        kStim.push_back(k);
        pd = peFunc(q, k);
        for (int t = 0; t < TS; t++) sums[t] += int'(pd[PW*t +: PW]);
      end
      for (int t = 0; t < TS; t++)
        e.data[ACC_W*t +: ACC_W] = ACC_W'(laneModel(sums[t], ACC_W));
      e.last = (p == nPairs - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic startJob(input int n);
    @(posedge s_clk); #1;
    i_start = 1'b1;
    i_pair_num = 16'(n);
    @(posedge s_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge s_clk);
      n++;
    end while (!o_done && n < maxCyc);
    checkOutput(name, o_done, 1);
    @(negedge s_clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int qBase, kBase, dBase, rBase, n, exp8, full;
    s_rst = 1'b1; i_start = 1'b0; i_pair_num = '0;
    s8Start = 1'b0; s8Go = 1'b0; s8Ones = '1;
    repeat (6) @(posedge s_clk);
    #1 s_rst = 1'b0;
    @(negedge s_clk);
    checkOutput("resetFlags", {o_busy, o_done, o_err, o_q_ready, o_k_ready,
                               o_pe_valid, o_score_valid, o_score_last}, 0);
    checkOutput("resetScore", o_score_data, 0);

    // Reset in the middle of issuing, then a clean one-pair job.
    $display("[TB] reset mid-issue");
    applyStimulus(1, 0, 0, 0);
    qBase = qUsed;
    startJob(1);
    n = 0;
    while (qUsed - qBase < 5 && n < 100) begin @(negedge s_clk); n++; end
    checkOutput("reachBeat5", qUsed - qBase, 5);
    s_rst = 1'b1;
    qStim.delete(); kStim.delete(); expQ.delete();
    repeat (6) @(posedge s_clk);
    #1 s_rst = 1'b0;
    @(negedge s_clk);
    checkOutput("postResetFlags", {o_busy, o_done, o_err, o_q_ready, o_k_ready,
                                   o_pe_valid, o_score_valid, o_score_last}, 0);
    applyStimulus(1, 0, 0, 0);
    startJob(1);
    waitDone(200, "doneAfterReset");
    checkOutput("scoresLeft1", expQ.size(), 0);

    // Two pairs, continuous valids, every PE lane result 15.
    $display("[TB] continuous two-pair job");
    qBase = qUsed; kBase = kUsed; dBase = donePulses; rBase = scoreRise.size();
    applyStimulus(2, 1, 0, 0);
    startJob(2);
    waitDone(300, "doneContinuous");
    checkOutput("donePulsesOnce", donePulses - dBase, 1);
    checkOutput("qConsumed2", qUsed - qBase, 2*CH);
    checkOutput("kConsumed2", kUsed - kBase, 2*CH);
    if (scoreRise.size() >= rBase + 2)
      checkOutput("pairPeriod", scoreRise[rBase+1] - scoreRise[rBase], CH + 3 + 2);
    else
      checkOutput("scoreCount", scoreRise.size() - rBase, 2);

    // Q valid toggling, K always valid, score ready held low for 10 cycles.
    $display("[TB] toggling Q valid with output stall");
    qBase = qUsed; kBase = kUsed;
    readyLevel = 1'b0;
    applyStimulus(2, 0, 1, 0);
    startJob(2);
    n = 0;
    while (!o_score_valid && n < 300) begin @(negedge s_clk); n++; end
    checkOutput("firstScoreSeen", o_score_valid, 1);
    repeat (10) @(negedge s_clk);
    readyLevel = 1'b1;
    waitDone(400, "doneToggle");
    checkOutput("qConsumedT", qUsed - qBase, 2*CH);
    checkOutput("kConsumedT", kUsed - kBase, 2*CH);

    // Random valids on both streams and random downstream ready.
    $display("[TB] random traffic");
    qBase = qUsed; kBase = kUsed;
    readyRandom = 1'b1;
    applyStimulus(3, 0, 2, 2);
    startJob(3);
    waitDone(2000, "doneRandom");
    readyRandom = 1'b0;
    checkOutput("qConsumedR", qUsed - qBase, 3*CH);
    checkOutput("kConsumedR", kUsed - kBase, 3*CH);
    checkOutput("scoresLeftR", expQ.size(), 0);

    // Spurious PE result in IDLE, empty job, then a job that clears the error.
    $display("[TB] spurious result and empty job");
    @(posedge s_clk); #1 spurious = 1'b1;
    @(posedge s_clk); #1 spurious = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge s_clk);
      checkOutput("errSticky", o_err, 1);
    end
    applyStimulus(1, 0, 0, 0);
    dBase = donePulses;
    startJob(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge s_clk);
      checkOutput("emptyNoReady", {o_q_ready, o_k_ready, o_busy}, 0);
    end
    checkOutput("emptyDone", donePulses - dBase, 1);
    startJob(1);
    @(negedge s_clk);
    checkOutput("errCleared", o_err, 0);
    waitDone(200, "doneAfterErr");

    // Narrow-lane instance: 24 results of 15 per lane.
    $display("[TB] narrow accumulator overflow");
    full = CH * 15;
`ifdef ATTN_SCHED_SAT_EN
    exp8 = (full > 255) ? 255 : full;
`else
    exp8 = full % 256;
`endif
    s8Go = 1'b1;
    @(posedge s_clk); #1 s8Start = 1'b1;
    @(posedge s_clk); #1 s8Start = 1'b0;
    n = 0;
    while (!s8ScoreValid && n < 200) begin @(negedge s_clk); n++; end
    checkOutput("s8ScoreSeen", s8ScoreValid, 1);
    for (int t = 0; t < TS; t++)
      checkOutput("s8Lane", s8ScoreData[8*t +: 8], exp8);
    checkOutput("s8Last", s8ScoreLast, 1);
    @(negedge s_clk);
    checkOutput("s8Done", s8Done, 1);
    s8Go = 1'b0;

    repeat (3) @(negedge s_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/attn_pe_scheduler.md
Name: attn_pe_scheduler

Overview:
- Sequences one Attention_PE for a job of N (query-row, key-row) pairs.
- For each pair:
  - Joins the Q and K spike-chunk streams and issues CHUNKS beats to the PE.
  - Accumulates the PE's per-time-step partial sums over all chunks.
  - Emits one TIME_STEPS-wide attention score vector through a valid/ready port.
- Sits between the Q/K spike buffers and the attention-score softmax-free scaling stage.

Parameters:
- SYSTOLIC_UNIT_NUM, 8, PE half-lane count; a chunk is 2*SYSTOLIC_UNIT_NUM spikes per time step.
- TIME_STEPS, 4, spike time steps per chunk; the PE datapath is fixed at 4.
- CHUNKS, 24, chunks per row (embedding dim / (2*SYSTOLIC_UNIT_NUM)); must be at least 1.
- PW, $clog2(2*SYSTOLIC_UNIT_NUM), width of each per-time-step PE sum.
- ACC_W, 10, width of each per-time-step accumulator and score lane.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  reset. Asynchronous, active-high.
- i_start  in  1  job start pulse. Sampled only in IDLE.
- i_pair_num  in  16  number of pairs in the job. Latched on an accepted i_start.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at job end.
- o_err  out  1  sticky: a PE result arrived when none was expected.
- i_q_valid  in  1  query chunk valid.
- i_q_data  in  2*SYSTOLIC_UNIT_NUM*TIME_STEPS  query chunk.
- o_q_ready  out  1  query chunk accepted.
- i_k_valid  in  1  key chunk valid.
- i_k_data  in  2*SYSTOLIC_UNIT_NUM*TIME_STEPS  key chunk.
- o_k_ready  out  1  key chunk accepted.
- o_pe_valid  out  1  drives the PE's i_Spikesdata_valid.
- o_pe_query  out  2*SYSTOLIC_UNIT_NUM*TIME_STEPS  drives the PE's query input.
- o_pe_key  out  2*SYSTOLIC_UNIT_NUM*TIME_STEPS  drives the PE's key input.
- i_pe_valid  in  1  PE o_Calc_valid.
- i_pe_data  in  PW*TIME_STEPS  PE o_Calc_data; lane t is bits [PW*(t+1)-1 : PW*t].
- o_score_valid  out  1  score vector valid.
- o_score_data  out  ACC_W*TIME_STEPS  score vector; lane t holds time step t.
- o_score_last  out  1  marks the last pair of the job.
- i_score_ready  in  1  downstream accept.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including o_err.
  - Counters and accumulators are cleared.
  - A job in flight is abandoned; the PE pipeline drains on its own, and results arriving in IDLE set o_err. The bench re-asserts reset long enough to cover the PE latency.
- IDLE:
  - i_start with i_pair_num != 0: latch pair count, clear o_err, go to ISSUE.
  - i_start with i_pair_num == 0: o_done pulses on the next cycle; stay in IDLE.
  - i_start outside IDLE is ignored.
- ISSUE:
  - o_q_ready = i_k_valid and o_k_ready = i_q_valid (combinational, only in ISSUE).
  - fire = i_q_valid & i_k_valid. A chunk is never consumed from one stream alone.
  - On fire, o_pe_valid goes to 1 on the next cycle, with o_pe_query/o_pe_key registered from the inputs. Otherwise o_pe_valid = 0 and the data holds.
  - One beat per cycle at most. Bubbles are allowed whenever either valid is low.
  - The issue counter increments on fire. On the CHUNKS-th fire, go to DRAIN.
- Accumulation, active in ISSUE and DRAIN:
  - On i_pe_valid: acc[t] <= acc[t] + zero-extended i_pe_data lane t, for each t, and the result counter increments.
  - When the result counter reaches CHUNKS: o_score_data <= acc + current beat, o_score_valid <= 1, o_score_last <= (pair counter == pair count - 1). Go to OUT.
  - The PE has no stall, so at most CHUNKS results are outstanding. No new pair is issued until the score handshake completes.
- OUT:
  - o_score_valid and o_score_data hold stable until i_score_ready.
  - On handshake, if it was the last pair: o_done pulses, o_score_valid drops, go to IDLE.
  - Otherwise: clear accumulators and counters, increment the pair counter, go to ISSUE.
  - Ready may be high before valid; no combinational path from ready to valid.
- Unexpected results: i_pe_valid in IDLE or OUT sets o_err and the data is dropped. i_pe_valid in ISSUE is legal (PE latency shorter than CHUNKS).
- Latency:
  - Score appears PE_latency + 1 cycles after the last issue beat.
  - Minimum per-pair period is CHUNKS + PE_latency + 2 cycles with continuous valid and ready.
- Width: lane sums are unsigned. Overflow handling is set by the optional feature below.

Optional Feature:
- Macro: ATTN_SCHED_SAT_EN.
- Defined: each accumulator lane saturates at 2^ACC_W-1 and stays there until cleared.
- Undefined: lanes wrap modulo 2^ACC_W.

Test Plan:
- Reset mid-ISSUE (beat 5 of 24), then release: all outputs 0, state IDLE; a new i_start with i_pair_num=1 completes normally with o_done one cycle after the handshake.
- i_pair_num=2, continuous valids, PE model latency 3, every lane result = 15: two scores of 360 per lane; o_score_last only on the second score; o_done pulses once; period = 24+3+2 cycles.
- Q valid toggling 1010…, K valid always 1: no beat is issued without both valids; exactly 24 fires per pair; each stream consumes exactly 24 chunks.
- i_score_ready held low for 10 cycles in OUT: score stable, no PE issue, no ready to Q/K; completion follows the first ready cycle.
- ACC_W=8, 24 results of 15: 255 per lane with ATTN_SCHED_SAT_EN, 104 without.
- Spurious i_pe_valid in IDLE: o_err = 1 and sticky; the next i_start clears it; i_start with i_pair_num=0 gives an o_done pulse and no Q/K ready.
